// File: rtl/williams2_dn_loader.sv
// ROM download sequencer: captures the HPS ioctl byte stream into a small FIFO,
// replays it to the williams2 core download port at a bounded rate, and gates core reset.
module williams2_dn_loader #(
  parameter logic [17:0] ROM_SIZE    = 18'd147456,
  parameter logic [15:0] INDEX       = 16'd0,
  parameter int          WR_GAP      = 2,
  parameter int          HOLD_CYCLES = 256,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clock_12,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [15:0] ioctl_index,
  output logic        ioctl_wait,
  output logic [17:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] checksum
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam int GW = $clog2(WR_GAP) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [OW-1:0] OCC_FULL   = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] OCC_WAIT   = OW'(FIFO_DEPTH - 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(WR_GAP - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_dl_prev;
  logic [25:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [OW-1:0]   r_occ;
  logic [GW-1:0]   r_gap;
  logic [HW-1:0]   r_hold;
  logic [17:0]     r_count;
  logic [15:0]     r_csum;
  logic            r_err;
  logic            r_done;
  logic            r_crst;
  logic            r_wait;
  logic [17:0]     r_dn_addr;
  logic [7:0]      r_dn_data;
  logic            r_dn_wr;

  logic            w_idx_ok;
  logic            w_rise;
  logic            w_fall;
  logic            w_go;
  logic            w_replay;
  logic            w_gap_zero;
  logic            w_empty;
  logic            w_full;
  logic            w_acc;
  logic            w_in_range;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic            w_bypass;
  logic            w_fifo_wr;
  logic            w_issue;
  logic            w_start;
  logic            w_hold_entry;
  logic            w_stay_done;
  logic [OW-1:0]   w_occ_nxt;
  logic [25:0]     w_head;

  assign w_idx_ok   = (ioctl_index == INDEX);
  assign w_rise     = ioctl_download & ~r_dl_prev;
  assign w_fall     = ~ioctl_download & r_dl_prev;
  assign w_go       = w_rise & w_idx_ok;
  assign w_replay   = (r_state == S_LOAD) | (r_state == S_DRAIN);
  assign w_gap_zero = (r_gap == '0);
  assign w_empty    = (r_occ == '0);
  assign w_full     = (r_occ == OCC_FULL);
  assign w_acc      = (r_state == S_LOAD) & ioctl_wr & ioctl_download & w_idx_ok;
  assign w_in_range = (ioctl_addr < {7'd0, ROM_SIZE});
  assign w_push     = w_acc & w_in_range & ~w_full;
  assign w_drop     = w_acc & ~(w_in_range & ~w_full);
  assign w_pop      = w_replay & ~w_empty & w_gap_zero;
  // An idle replay path forwards the byte straight to the core for single-cycle latency.
  assign w_bypass   = w_push & w_replay & w_empty & w_gap_zero;
  assign w_fifo_wr  = w_push & ~w_bypass;
  assign w_issue    = w_pop | w_bypass;
  assign w_occ_nxt  = r_occ + {{(OW-1){1'b0}}, w_fifo_wr} - {{(OW-1){1'b0}}, w_pop};
  assign w_head     = r_mem[r_rptr];
  assign w_stay_done = (r_state == S_DONE) & (w_state_nxt == S_DONE);

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_hold_entry = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_go) begin
          w_state_nxt = S_LOAD;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_LOAD: begin
        if (w_fall) w_state_nxt = S_DRAIN;
        else        w_state_nxt = S_LOAD;
      end
      S_DRAIN: begin
        if (w_empty & w_gap_zero) begin
          w_state_nxt  = S_HOLD;
          w_hold_entry = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (r_hold == HOLD_LAST) begin
          if (w_go) begin
            w_state_nxt = S_LOAD;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset value of 1 on the edge detector ignores a download already running at reset release.
  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dl_prev <= 1'b1;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dl_prev <= ioctl_download;
      if (w_start | w_hold_entry)
        r_hold <= '0;
      else if ((r_state == S_HOLD) && (r_hold != HOLD_LAST))
        r_hold <= r_hold + 1'b1;
    end
  end

  always_ff @(posedge clock_12) begin
    if (w_fifo_wr) r_mem[r_wptr] <= {ioctl_addr[17:0], ioctl_dout};
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_wait <= 1'b0;
      r_gap  <= '0;
    end else begin
      if (w_fifo_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_occ  <= w_occ_nxt;
      r_wait <= (w_occ_nxt >= OCC_WAIT);
      if (w_issue)          r_gap <= GAP_RELOAD;
      else if (!w_gap_zero) r_gap <= r_gap - 1'b1;
    end
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      r_dn_addr <= 18'd0;
      r_dn_data <= 8'd0;
      r_dn_wr   <= 1'b0;
    end else begin
      r_dn_wr <= w_issue;
      if (w_issue) begin
        r_dn_addr <= w_bypass ? ioctl_addr[17:0] : w_head[25:8];
        r_dn_data <= w_bypass ? ioctl_dout       : w_head[7:0];
      end
    end
  end

  // A short image is flagged when the drain completes, so a bad load keeps the core held.
  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      r_count <= 18'd0;
      r_csum  <= 16'd0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_crst  <= 1'b1;
    end else begin
      if (w_start) begin
        r_count <= 18'd0;
        r_csum  <= 16'd0;
      end else if (w_push) begin
        r_count <= r_count + 18'd1;
        r_csum  <= r_csum + {8'd0, ioctl_dout};
      end
      if (w_start)
        r_err <= 1'b0;
      else if (w_drop | (w_hold_entry & (r_count != ROM_SIZE)))
        r_err <= 1'b1;
      r_done <= w_stay_done;
      r_crst <= ~(w_stay_done & ~r_err);
    end
  end

  assign ioctl_wait = r_wait;
  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_wr      = r_dn_wr;
  assign core_reset = r_crst;
  assign load_done  = r_done;
  assign load_error = r_err;
  assign checksum   = r_csum;

endmodule

// File: tb/tb_williams2_dn_loader.sv
// Directed bench for williams2_dn_loader: a per-cycle vector table plus
// multi-cycle image, short-image, wrong-index and mid-burst reset sequences.
module tb_williams2_dn_loader;

  logic        clock_12 = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [15:0] ioctl_index = 16'd0;
  logic        ioctl_wait;
  logic [17:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        load_done;
  logic        load_error;
  logic [15:0] checksum;

  williams2_dn_loader #(
    .ROM_SIZE(18'd16), .INDEX(16'd0), .WR_GAP(2), .HOLD_CYCLES(4), .FIFO_DEPTH(4)
  ) dut (
    .clock_12(clock_12), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .dn_addr(dn_addr),
    .dn_data(dn_data), .dn_wr(dn_wr), .core_reset(core_reset),
    .load_done(load_done), .load_error(load_error), .checksum(checksum)
  );

  always #5 clock_12 = ~clock_12;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [17:0] q_addr[$];
  logic [7:0]  q_data[$];
  int          q_cyc[$];

  always @(posedge clock_12) cyc <= cyc + 1;

  always @(negedge clock_12) begin
    if (!reset && dn_wr) begin
      q_addr.push_back(dn_addr);
      q_data.push_back(dn_data);
      q_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic        dl;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [15:0] idx;
    logic        e_wr;
    logic [17:0] e_addr;
    logic [7:0]  e_data;
    logic [15:0] e_cs;
    logic        e_err;
    logic        e_crst;
    logic        e_wait;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(input logic dl, input logic wr, input int addr, input int data,
                              input int idx, input logic e_wr, input int e_addr, input int e_data,
                              input int e_cs, input logic e_err, input logic e_crst, input logic e_wait);
    vec_t v;
    v.dl = dl; v.wr = wr; v.addr = 25'(addr); v.data = 8'(data); v.idx = 16'(idx);
    v.e_wr = e_wr; v.e_addr = 18'(e_addr); v.e_data = 8'(e_data); v.e_cs = 16'(e_cs);
    v.e_err = e_err; v.e_crst = e_crst; v.e_wait = e_wait;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_12);
    #1;
  endtask

  task automatic drive(input logic dl, input logic wr, input int addr, input int data, input int idx);
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_addr     = 25'(addr);
    ioctl_dout     = 8'(data);
    ioctl_index    = 16'(idx);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dn_addr"}, int'(dn_addr), 0);
    chk({tag, "_dn_data"}, int'(dn_data), 0);
    chk({tag, "_dn_wr"}, int'(dn_wr), 0);
    chk({tag, "_wait"}, int'(ioctl_wait), 0);
    chk({tag, "_core_reset"}, int'(core_reset), 1);
    chk({tag, "_load_done"}, int'(load_done), 0);
    chk({tag, "_load_error"}, int'(load_error), 0);
    chk({tag, "_checksum"}, int'(checksum), 0);
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  // Byte i goes to address i with data i; the final byte may be redirected to last_addr.
  task automatic send_image(input int n, input int last_addr, output bit saw_wait);
    int i = 0;
    int guard = 0;
    saw_wait = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0);
    tick();
    while (i < n && guard < 200) begin
      if (!ioctl_wait) begin
        drive(1'b1, 1'b1, (i == n - 1) ? last_addr : i, i, 0);
        i++;
      end else begin
        drive(1'b1, 1'b0, 0, 0, 0);
        saw_wait = 1'b1;
      end
      tick();
      guard++;
    end
    chk("feed_budget", i, n);
    drive(1'b1, 1'b0, 0, 0, 0);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0);
    tick();
  endtask

  task automatic wait_done(output int crst_fall);
    bit ok = 1'b0;
    crst_fall = -1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!core_reset && crst_fall < 0) crst_fall = cyc;
      if (load_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", int'(ok), 1);
  endtask

  task automatic verify_pulses(input string tag, input int n);
    chk({tag, "_pulse_count"}, q_addr.size(), n);
    for (int k = 0; k < q_addr.size() && k < n; k++) begin
      chk($sformatf("%s_p%0d_addr", tag, k), int'(q_addr[k]), k);
      chk($sformatf("%s_p%0d_data", tag, k), int'(q_data[k]), k);
      if (k > 0) chk($sformatf("%s_p%0d_gap", tag, k), q_cyc[k] - q_cyc[k-1], 2);
    end
  endtask

  initial begin
    bit saw;
    int fall;
    int last;
    int hits;

    vt[0]  = mk(1'b0, 1'b0,  0, 8'h00, 0, 1'b0, 0, 8'h00, 16'h00, 1'b0, 1'b1, 1'b0);
    vt[1]  = mk(1'b1, 1'b0,  0, 8'h00, 0, 1'b0, 0, 8'h00, 16'h00, 1'b0, 1'b1, 1'b0);
    vt[2]  = mk(1'b1, 1'b1,  5, 8'hA5, 0, 1'b1, 5, 8'hA5, 16'hA5, 1'b0, 1'b1, 1'b0);
    vt[3]  = mk(1'b1, 1'b0,  0, 8'h00, 0, 1'b0, 5, 8'hA5, 16'hA5, 1'b0, 1'b1, 1'b0);
    vt[4]  = mk(1'b1, 1'b1,  3, 8'h10, 0, 1'b1, 3, 8'h10, 16'hB5, 1'b0, 1'b1, 1'b0);
    vt[5]  = mk(1'b1, 1'b1,  7, 8'h20, 0, 1'b0, 3, 8'h10, 16'hD5, 1'b0, 1'b1, 1'b0);
    vt[6]  = mk(1'b1, 1'b0,  0, 8'h00, 0, 1'b1, 7, 8'h20, 16'hD5, 1'b0, 1'b1, 1'b0);
    vt[7]  = mk(1'b1, 1'b1,  2, 8'h55, 1, 1'b0, 7, 8'h20, 16'hD5, 1'b0, 1'b1, 1'b0);
    vt[8]  = mk(1'b1, 1'b1, 16, 8'hFF, 0, 1'b0, 7, 8'h20, 16'hD5, 1'b1, 1'b1, 1'b0);
    vt[9]  = mk(1'b1, 1'b0,  0, 8'h00, 0, 1'b0, 7, 8'h20, 16'hD5, 1'b1, 1'b1, 1'b0);
    vt[10] = mk(1'b0, 1'b0,  0, 8'h00, 0, 1'b0, 7, 8'h20, 16'hD5, 1'b1, 1'b1, 1'b0);

    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    for (int v = 0; v < 11; v++) begin
      drive(vt[v].dl, vt[v].wr, int'(vt[v].addr), int'(vt[v].data), int'(vt[v].idx));
      tick();
      chk($sformatf("v%0d_dn_wr", v), int'(dn_wr), int'(vt[v].e_wr));
      chk($sformatf("v%0d_dn_addr", v), int'(dn_addr), int'(vt[v].e_addr));
      chk($sformatf("v%0d_dn_data", v), int'(dn_data), int'(vt[v].e_data));
      chk($sformatf("v%0d_checksum", v), int'(checksum), int'(vt[v].e_cs));
      chk($sformatf("v%0d_load_error", v), int'(load_error), int'(vt[v].e_err));
      chk($sformatf("v%0d_core_reset", v), int'(core_reset), int'(vt[v].e_crst));
      chk($sformatf("v%0d_wait", v), int'(ioctl_wait), int'(vt[v].e_wait));
    end
    wait_done(fall);
    chk("tbl_end_error", int'(load_error), 1);
    chk("tbl_end_core_reset", int'(core_reset), 1);

    // Full 16-byte image with back-pressure honoured.
    clear_q();
    send_image(16, 15, saw);
    wait_done(fall);
    chk("full_saw_wait", int'(saw), 1);
    chk("full_checksum", int'(checksum), 120);
    chk("full_error", int'(load_error), 0);
    chk("full_done", int'(load_done), 1);
    chk("full_core_reset", int'(core_reset), 0);
    verify_pulses("full", 16);
    last = (q_cyc.size() > 0) ? q_cyc[q_cyc.size()-1] : 0;
    chk("full_release_delay", fall - last, 7);

    // Short image: 15 bytes.
    clear_q();
    send_image(15, 14, saw);
    wait_done(fall);
    chk("short_error", int'(load_error), 1);
    chk("short_done", int'(load_done), 1);
    chk("short_core_reset", int'(core_reset), 1);
    chk("short_checksum", int'(checksum), 105);
    verify_pulses("short", 15);

    // Last byte redirected out of range to address 16.
    clear_q();
    send_image(16, 16, saw);
    wait_done(fall);
    chk("oor_error", int'(load_error), 1);
    chk("oor_core_reset", int'(core_reset), 1);
    chk("oor_checksum", int'(checksum), 105);
    hits = 0;
    foreach (q_addr[k]) if (q_addr[k] == 18'd16) hits++;
    chk("oor_addr16_writes", hits, 0);
    verify_pulses("oor", 15);

    // Wrong index download after a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_q();
    drive(1'b0, 1'b0, 0, 0, 1);
    tick();
    drive(1'b1, 1'b0, 0, 0, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, k, 8'h11 + k, 1);
      tick();
    end
    drive(1'b0, 1'b0, 0, 0, 1);
    repeat (12) tick();
    chk("idx_pulses", q_addr.size(), 0);
    chk("idx_core_reset", int'(core_reset), 1);
    chk("idx_done", int'(load_done), 0);
    chk("idx_checksum", int'(checksum), 0);

    // Reset asserted mid-burst, then a clean reload.
    drive(1'b0, 1'b0, 0, 0, 0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, k, 8'h30 + k, 0);
      tick();
    end
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    tick();
    tick();
    reset = 1'b0;
    clear_q();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, k, 8'h40, 0);
      tick();
    end
    drive(1'b1, 1'b0, 0, 0, 0);
    repeat (4) tick();
    chk("midrst_ignored_pulses", q_addr.size(), 0);
    chk("midrst_ignored_checksum", int'(checksum), 0);
    clear_q();
    send_image(16, 15, saw);
    wait_done(fall);
    chk("reload_checksum", int'(checksum), 120);
    chk("reload_error", int'(load_error), 0);
    chk("reload_core_reset", int'(core_reset), 0);
    verify_pulses("reload", 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
